// File: rtl/lea_pkg.sv
// Shared constants, state encoding and word helpers for the LEA-128 decryption key schedule.
package lea_pkg;
    localparam int NR = 24;
    localparam int RW = 5;
    localparam logic [RW-1:0] LAST_RND = RW'(NR - 1);

    localparam logic [31:0] DELTA [4] = '{32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec};
    localparam logic [4:0]  ROT   [4] = '{5'd1, 5'd3, 5'd6, 5'd11};

    typedef enum logic [1:0] {IDLE, FWD, EMIT} state_t;

    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] w;
        w = {x, x} << n;
        return w[63:32];
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        return rol32(x, 5'd0 - n);
    endfunction

    // Round-key word order expected by the round datapath: {T0,T1,T2,T1,T3,T1}.
    function automatic logic [191:0] pack_rk(input logic [127:0] t);
        return {t[127:96], t[95:64], t[63:32], t[95:64], t[31:0], t[95:64]};
    endfunction
endpackage

// File: rtl/lea_dec_keysched_step.sv
// One LEA-128 key-schedule step on the 4-word state, forward or inverse (combinational).
module lea_ks_step
    import lea_pkg::*;
(
    input  logic [127:0] t_in,
    input  logic [4:0]   rnd,
    input  logic         dir,
    output logic [127:0] t_out
);
    logic [31:0] d;
    assign d = DELTA[rnd[1:0]];

    // Word k uses ROL(d, i+k); i+k never exceeds 26, so no wrap of the 5-bit sum.
    for (genvar k = 0; k < 4; k++) begin : g_word
        logic [31:0] w;
        logic [31:0] c;
        assign w = t_in[127-32*k -: 32];
        assign c = rol32(d, rnd + 5'(k));
        assign t_out[127-32*k -: 32] = dir ? (ror32(w, ROT[k]) - c) : rol32(w + c, ROT[k]);
    end
endmodule

// File: rtl/lea_dec_keysched.sv
// LEA-128 decryption round-key generator: runs the schedule forward 24 steps, then emits
// round keys 23..0 by stepping the state backwards, one per rk handshake.
module lea_dec_keysched
    import lea_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          key_valid,
    output logic          key_ready,
    input  logic [127:0]  key,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [191:0]  rk,
    output logic [RW-1:0] rk_round,
    output logic          rk_last,
    output logic          busy
);
    state_t          state_q, state_d;
    logic [127:0]    t_q, t_d;
    logic [RW-1:0]   cnt_q, cnt_d;
    logic [191:0]    rk_q, rk_d;
    logic            rk_last_q, rk_last_d;
    logic [127:0]    t_step;
    logic            step_dir;

    assign step_dir = (state_q == EMIT);

    lea_ks_step u_step (
        .t_in  (t_q),
        .rnd   (cnt_q),
        .dir   (step_dir),
        .t_out (t_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            t_q       <= '0;
            cnt_q     <= '0;
            rk_q      <= '0;
            rk_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            cnt_q     <= cnt_d;
            rk_q      <= rk_d;
            rk_last_q <= rk_last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        cnt_d     = cnt_q;
        rk_d      = rk_q;
        rk_last_d = rk_last_q;
        unique case (state_q)
            IDLE: begin
                if (key_valid) begin
                    t_d     = key;
                    cnt_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                t_d = t_step;
                // The last forward step also preloads the first key so rk_valid and rk rise together.
                if (cnt_q == LAST_RND) begin
                    state_d   = EMIT;
                    rk_d      = pack_rk(t_step);
                    rk_last_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (cnt_q == '0) begin
                        state_d   = IDLE;
                        rk_last_d = 1'b0;
                    end else begin
                        t_d       = t_step;
                        cnt_d     = cnt_q - 1'b1;
                        rk_d      = pack_rk(t_step);
                        rk_last_d = (cnt_q == RW'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign key_ready = (state_q == IDLE);
    assign rk_valid  = (state_q == EMIT);
    assign busy      = (state_q != IDLE);
    assign rk        = rk_q;
    assign rk_round  = cnt_q;
    assign rk_last   = rk_last_q;
endmodule

// File: tb/tb_lea_dec_keysched.sv
// Directed bench for lea_dec_keysched: reference keys from a forward schedule model, reversed.
module tb_lea_dec_keysched;
    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [191:0] rk;
    logic [4:0]   rk_round;
    logic         rk_last;
    logic         busy;

    int total = 0;
    int bad   = 0;
    logic [191:0] rk_exp [24];

    always #5 clk = ~clk;

    lea_dec_keysched dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk        (rk),
        .rk_round  (rk_round),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        int m;
        m = n % 32;
        if (m == 0) return x;
        return (x << m) | (x >> (32 - m));
    endfunction

    task automatic gen_exp(input logic [127:0] k);
        logic [31:0] t [4];
        logic [31:0] dl [4];
        logic [31:0] d;
        dl[0] = 32'hc3efe9db; dl[1] = 32'h44626b02; dl[2] = 32'h79e27c8a; dl[3] = 32'h78df30ec;
        t[0] = k[127:96]; t[1] = k[95:64]; t[2] = k[63:32]; t[3] = k[31:0];
        for (int i = 0; i < 24; i++) begin
            d = dl[i % 4];
            t[0] = rl(t[0] + rl(d, i), 1);
            t[1] = rl(t[1] + rl(d, i + 1), 3);
            t[2] = rl(t[2] + rl(d, i + 2), 6);
            t[3] = rl(t[3] + rl(d, i + 3), 11);
            rk_exp[i] = {t[0], t[1], t[2], t[1], t[3], t[1]};
        end
    endtask

    task automatic send_key(input logic [127:0] k);
        int n;
        n = 0;
        while (key_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_key_wait key_ready=%b required=1", key_ready);
        end
        key = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; key_valid = 1'b0; key = '0; rk_ready = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({key_ready, rk_valid, rk_last, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_flags got=%b required=1000", {key_ready, rk_valid, rk_last, busy});
        end
        total++;
        if (rk !== 192'd0 || rk_round !== 5'd0) begin
            bad++;
            $display("FAIL reset_rk got rk=%h round=%0d required 0/0", rk, rk_round);
        end
        #3 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release key_ready=%b busy=%b required 1/0", key_ready, busy);
        end
    endtask

    task automatic test_zero_key();
        gen_exp(128'd0);
        rk_ready = 1'b1;
        send_key(128'd0);
        total++;
        if (key_ready !== 1'b0 || rk_valid !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL zero_e1 key_ready=%b rk_valid=%b busy=%b required 0/0/1", key_ready, rk_valid, busy);
        end
        for (int n = 1; n <= 24; n++) begin
            @(posedge clk); #1;
            total++;
            if (rk_valid !== (n == 24) || key_ready !== 1'b0) begin
                bad++;
                $display("FAIL zero_latency edge=%0d rk_valid=%b key_ready=%b required %b/0", n, rk_valid, key_ready, n == 24);
            end
        end
        for (int r = 23; r >= 0; r--) begin
            total++;
            if (rk_valid !== 1'b1 || rk_round !== 5'(r) || rk !== rk_exp[r] || rk_last !== (r == 0)) begin
                bad++;
                $display("FAIL zero_seq got v=%b round=%0d last=%b rk=%h required round=%0d rk=%h",
                         rk_valid, rk_round, rk_last, rk, r, rk_exp[r]);
            end
            if (r == 0) begin
                total++;
                if (rk !== 192'h87dfd3b7_3efe9dbc_efe9dbc3_3efe9dbc_fa76f0fb_3efe9dbc || rk_last !== 1'b1) begin
                    bad++;
                    $display("FAIL zero_last_vector got rk=%h last=%b required rk=87dfd3b73efe9dbcefe9dbc33efe9dbcfa76f0fb3efe9dbc last=1", rk, rk_last);
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_after key_ready=%b rk_valid=%b busy=%b required 1/0/0", key_ready, rk_valid, busy);
        end
    endtask

    task automatic test_stalls(input logic [127:0] k);
        int idx, hs, cyc;
        logic stalled;
        logic [191:0] prev_rk;
        gen_exp(k);
        rk_ready = 1'b0;
        send_key(k);
        idx = 23; hs = 0; cyc = 0; stalled = 1'b0; prev_rk = '0;
        while (rk_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        cyc = 0;
        while (idx >= 0 && cyc < 1000) begin
            if (rk_valid === 1'b1) begin
                total++;
                if (rk_round !== 5'(idx) || rk !== rk_exp[idx]) begin
                    bad++;
                    $display("FAIL stall_seq got round=%0d rk=%h required round=%0d rk=%h", rk_round, rk, idx, rk_exp[idx]);
                end
                total++;
                if (rk[159:128] !== rk[95:64] || rk[31:0] !== rk[95:64]) begin
                    bad++;
                    $display("FAIL stall_t1_words got %h %h %h required all equal", rk[159:128], rk[95:64], rk[31:0]);
                end
                if (stalled) begin
                    total++;
                    if (rk !== prev_rk) begin
                        bad++;
                        $display("FAIL stall_hold got rk=%h required %h", rk, prev_rk);
                    end
                end
            end
            prev_rk = rk;
            rk_ready = ($urandom_range(0, 99) >= 30);
            stalled = !rk_ready;
            if (rk_valid === 1'b1 && rk_ready) begin
                hs++; idx--;
            end
            @(posedge clk); #1; cyc++;
        end
        rk_ready = 1'b0;
        total++;
        if (hs != 24 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL stall_end handshakes=%0d rk_valid=%b key_ready=%b required 24/0/1", hs, rk_valid, key_ready);
        end
    endtask

    task automatic test_back_to_back(input logic [127:0] k);
        int cyc;
        gen_exp(k);
        rk_ready = 1'b1;
        send_key(k);
        cyc = 0;
        while (rk_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        for (int r = 23; r >= 0; r--) begin
            total++;
            if (rk_valid !== 1'b1 || rk_round !== 5'(r) || rk !== rk_exp[r]) begin
                bad++;
                $display("FAIL b2b_seq key=%h got v=%b round=%0d rk=%h required round=%0d rk=%h",
                         k, rk_valid, rk_round, rk, r, rk_exp[r]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_key();
        logic [127:0] ka;
        int cyc;
        ka = 128'h01234567_89abcdef_fedcba98_76543210;
        gen_exp(ka);
        rk_ready = 1'b1;
        send_key(ka);
        repeat (5) @(posedge clk);
        #1;
        key = 128'hdeadbeef_cafef00d_11111111_22222222;
        key_valid = 1'b1;
        total++;
        if (key_ready !== 1'b0) begin
            bad++;
            $display("FAIL ignore_fwd_ready key_ready=%b required 0", key_ready);
        end
        @(posedge clk); #1;
        key_valid = 1'b0;
        cyc = 0;
        while (rk_valid !== 1'b1 && cyc < 100) begin
            @(posedge clk); #1; cyc++;
        end
        for (int r = 23; r >= 0; r--) begin
            key_valid = (r == 15);
            total++;
            if (rk_valid !== 1'b1 || rk_round !== 5'(r) || rk !== rk_exp[r]) begin
                bad++;
                $display("FAIL ignore_seq got v=%b round=%0d rk=%h required round=%0d rk=%h",
                         rk_valid, rk_round, rk, r, rk_exp[r]);
            end
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        total++;
        if (key_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ignore_end key_ready=%b busy=%b required 1/0", key_ready, busy);
        end
    endtask

    task automatic test_async_reset();
        int cyc;
        rk_ready = 1'b1;
        send_key(128'h11223344_55667788_99aabbcc_ddeeff00);
        cyc = 0;
        while (!(rk_valid === 1'b1 && rk_round === 5'd10) && cyc < 200) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (rk_round !== 5'd10 || rk_valid !== 1'b1) begin
            bad++;
            $display("FAIL areset_reach round=%0d v=%b required 10/1", rk_round, rk_valid);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({key_ready, rk_valid, rk_last, busy} !== 4'b1000 || rk !== 192'd0 || rk_round !== 5'd0) begin
            bad++;
            $display("FAIL areset_outputs flags=%b rk=%h round=%0d required 1000/0/0",
                     {key_ready, rk_valid, rk_last, busy}, rk, rk_round);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        total++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            bad++;
            $display("FAIL areset_release rk_valid=%b key_ready=%b required 0/1", rk_valid, key_ready);
        end
        test_back_to_back(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_back_to_back(128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
        test_back_to_back(128'hffffffff_00000001_80000000_a5a5a5a5);
        test_stalls(128'h3c2d1e0f_78695a4b_b4a59687_f0e1d2c3);
        test_ignore_key();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
